servo_drive_scheduler: RTL and testbench
========================================

SERVO_DRIVE_SCHEDULER -- requirements
Module: servo_drive_scheduler

Parameters
REQ-001 The block SHALL have parameter PERIOD, default 2000000, giving the PWM frame length in clk cycles (20 ms at 100 MHz).
REQ-002 The block SHALL have parameter HOLD_PERIODS, default 2, giving the number of brake frames inserted on a direction reversal.
REQ-003 The block SHALL have parameter TIMEOUT_PERIODS, default 25, giving the number of frames without an accepted request before a forced brake.

Interface
REQ-004 clk  in  1  clock; all logic on the rising edge.
REQ-005 reset  in  1  reset; synchronous, active-high.
REQ-006 ovr_valid  in  1  override requester has a pending command; held until ovr_grant.
REQ-007 ovr_cmd  in  2  override command: 00 brake, 01 forward, 10 reverse, 11 treated as brake.
REQ-008 nav_valid  in  1  navigation requester has a pending command; held until nav_grant.
REQ-009 nav_cmd  in  2  navigation command; same encoding as ovr_cmd.
REQ-010 ovr_grant  out  1  single-cycle pulse when the ovr command is accepted.
REQ-011 nav_grant  out  1  single-cycle pulse when the nav command is accepted.
REQ-012 count_out  out  30  frame counter fed to the PWM generator's count input.
REQ-013 period_tick  out  1  high in the last cycle of each frame.
REQ-014 direction  out  1  1 selects the forward pulse width, 0 the reverse pulse width.
REQ-015 motor_brake  out  1  1 selects the neutral/brake pulse width; overrides direction.
REQ-016 timeout  out  1  high while the forced-brake condition is in effect.

Function
REQ-017 count_out SHALL increment by 1 each cycle and wrap from PERIOD-1 to 0; period_tick SHALL be 1 exactly when count_out == PERIOD-1.
REQ-018 Arbitration, grants and state changes SHALL occur only on the rising edge that ends a cycle in which period_tick == 1, so new direction/motor_brake values first appear with count_out == 0 and stay constant for the whole frame.
REQ-019 At a boundary, if ovr_valid == 1, ovr SHALL be granted; otherwise, if nav_valid == 1, nav SHALL be granted; at most one grant SHALL be issued per boundary, and a losing request SHALL remain pending.
REQ-020 The FSM SHALL have the states BRAKE, FWD, REV and TRANSIT.
REQ-021 In BRAKE and TRANSIT, motor_brake SHALL be 1; in FWD and REV, motor_brake SHALL be 0 and direction SHALL be 1 in FWD and 0 in REV.
REQ-022 In BRAKE and TRANSIT, direction SHALL keep its previous value.
REQ-023 A granted brake command (00 or 11) SHALL move the FSM to BRAKE from any state other than TRANSIT.
REQ-024 A granted forward command SHALL move BRAKE or FWD to FWD, and a granted reverse command SHALL move BRAKE or REV to REV.
REQ-025 A granted reverse command in FWD, or a granted forward command in REV, SHALL move the FSM to TRANSIT, latch the target direction, and load the hold counter with HOLD_PERIODS.
REQ-026 TRANSIT SHALL decrement the hold counter at each boundary, SHALL issue no grants, and SHALL move to the latched target state at the boundary where the counter reaches 0, giving exactly HOLD_PERIODS brake frames.
REQ-027 The idle counter SHALL clear on every grant, SHALL increment at each boundary with no grant outside TRANSIT, and SHALL pause in TRANSIT.
REQ-028 When the idle counter reaches TIMEOUT_PERIODS, the FSM SHALL enter BRAKE at that boundary and timeout SHALL go to 1.
REQ-029 timeout SHALL clear on the next grant.
REQ-030 Before timeout, repeated grants of the current command SHALL leave the outputs unchanged and only clear the idle counter.

Reset
REQ-031 When reset == 1, the block SHALL set count_out=0, state=BRAKE, motor_brake=1, direction=0, ovr_grant=0, nav_grant=0, timeout=0, and clear the hold and idle counters.
REQ-032 A reset asserted mid-frame or during TRANSIT SHALL abandon the transition with no pending target retained.
REQ-033 Requests held across reset SHALL be considered only at the first boundary after reset deasserts.

Verification (run with PERIOD=10, HOLD_PERIODS=2, TIMEOUT_PERIODS=3)
REQ-034 Reset then free-run -> count_out sequence 0..9,0; period_tick high only at 9; motor_brake=1.
REQ-035 nav_valid=1, nav_cmd=01 raised at count 3 -> nav_grant pulses at count 9; from count 0, direction=1 and motor_brake=0.
REQ-036 Both requesters valid at a boundary (ovr=10, nav=01) in BRAKE -> ovr_grant only, state REV; nav is granted at the following boundary and the FSM enters TRANSIT.
REQ-037 In FWD, a granted reverse command -> motor_brake=1 for exactly 2 frames (20 cycles), then direction=0 and motor_brake=0; a request during TRANSIT is not granted until TRANSIT exits.
REQ-038 In FWD with no requests -> after 3 idle boundaries, motor_brake=1 and timeout=1; a subsequent grant clears timeout.
REQ-039 Reset pulsed during TRANSIT at count 5 -> the state returns to BRAKE with count_out=0, and no direction change follows.

Source files
------------

// File: rtl/servo_drive_scheduler_if.sv
// Request/grant bundle between the two command sources (override, navigation)
// and the servo drive scheduler.
interface servo_drive_scheduler_if;
    logic       ovr_valid;
    logic [1:0] ovr_cmd;
    logic       nav_valid;
    logic [1:0] nav_cmd;
    logic       ovr_grant;
    logic       nav_grant;

    modport master (
        output ovr_valid,
        output ovr_cmd,
        output nav_valid,
        output nav_cmd,
        input  ovr_grant,
        input  nav_grant
    );

    modport slave (
        input  ovr_valid,
        input  ovr_cmd,
        input  nav_valid,
        input  nav_cmd,
        output ovr_grant,
        output nav_grant
    );
endinterface

// File: rtl/servo_drive_scheduler.sv
// Frame-synchronous servo drive scheduler: PWM frame counter, two-source priority
// arbitration, direction-reversal brake hold and idle-timeout forced brake.
module servo_drive_scheduler #(
    parameter int unsigned PERIOD          = 2000000,
    parameter int unsigned HOLD_PERIODS    = 2,
    parameter int unsigned TIMEOUT_PERIODS = 25
) (
    input  logic                   clk,
    input  logic                   reset,
    servo_drive_scheduler_if.slave bus,
    output logic [29:0]            count_out,
    output logic                   period_tick,
    output logic                   direction,
    output logic                   motor_brake,
    output logic                   timeout
);
    localparam logic [29:0]        LAST_COUNT = 30'(PERIOD - 1);
    localparam int unsigned        HOLD_W     = $clog2(HOLD_PERIODS + 2);
    localparam int unsigned        IDLE_W     = $clog2(TIMEOUT_PERIODS + 2);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_PERIODS);
    localparam logic [IDLE_W-1:0]  IDLE_LIMIT = IDLE_W'(TIMEOUT_PERIODS);

    typedef enum logic [1:0] {
        ST_BRAKE   = 2'b00,
        ST_FWD     = 2'b01,
        ST_REV     = 2'b10,
        ST_TRANSIT = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        CMD_BRAKE = 2'b00,
        CMD_FWD   = 2'b01,
        CMD_REV   = 2'b10
    } cmd_e;

    // The reserved encoding 11 is folded into brake so it can never drive the motor.
    function automatic cmd_e decode_cmd(input logic [1:0] raw);
        case (raw)
            2'b01:   decode_cmd = CMD_FWD;
            2'b10:   decode_cmd = CMD_REV;
            default: decode_cmd = CMD_BRAKE;
        endcase
    endfunction

    logic [29:0]       count_q, count_d;
    logic              tick_q, tick_d;
    state_e            state_q, state_d;
    logic              target_fwd_q, target_fwd_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              timeout_q, timeout_d;
    logic              direction_q, direction_d;
    logic              brake_q, brake_d;

    logic              boundary_s;
    logic              ovr_gnt_s;
    logic              nav_gnt_s;
    cmd_e              sel_cmd_s;

    assign boundary_s = tick_q;

    // Frame counter next state; the tick is registered alongside the count.
    always_comb begin
        count_d = count_q + 30'd1;
        if (tick_q) begin
            count_d = 30'd0;
        end else begin
            count_d = count_q + 30'd1;
        end
        tick_d = (count_d == LAST_COUNT);
    end

    // Grants are decided in the boundary cycle itself so a request held until
    // grant is seen by the requester before the closing edge.
    always_comb begin
        ovr_gnt_s = 1'b0;
        nav_gnt_s = 1'b0;
        sel_cmd_s = CMD_BRAKE;
        if (boundary_s && (state_q != ST_TRANSIT)) begin
            if (bus.ovr_valid) begin
                ovr_gnt_s = 1'b1;
                sel_cmd_s = decode_cmd(bus.ovr_cmd);
            end else if (bus.nav_valid) begin
                nav_gnt_s = 1'b1;
                sel_cmd_s = decode_cmd(bus.nav_cmd);
            end else begin
                ovr_gnt_s = 1'b0;
                nav_gnt_s = 1'b0;
                sel_cmd_s = CMD_BRAKE;
            end
        end else begin
            ovr_gnt_s = 1'b0;
            nav_gnt_s = 1'b0;
            sel_cmd_s = CMD_BRAKE;
        end
    end

    // Drive FSM next state, hold/idle counters and timeout flag.
    always_comb begin
        state_d      = state_q;
        target_fwd_d = target_fwd_q;
        hold_d       = hold_q;
        idle_d       = idle_q;
        timeout_d    = timeout_q;
        if (!boundary_s) begin
            state_d = state_q;
        end else if (state_q == ST_TRANSIT) begin
            if (hold_q <= HOLD_W'(1)) begin
                state_d = target_fwd_q ? ST_FWD : ST_REV;
                hold_d  = '0;
            end else begin
                hold_d = hold_q - HOLD_W'(1);
            end
        end else if (ovr_gnt_s || nav_gnt_s) begin
            idle_d    = '0;
            timeout_d = 1'b0;
            case (sel_cmd_s)
                CMD_FWD: begin
                    if ((state_q == ST_REV) && (HOLD_PERIODS != 0)) begin
                        state_d      = ST_TRANSIT;
                        target_fwd_d = 1'b1;
                        hold_d       = HOLD_LOAD;
                    end else begin
                        state_d = ST_FWD;
                    end
                end
                CMD_REV: begin
                    if ((state_q == ST_FWD) && (HOLD_PERIODS != 0)) begin
                        state_d      = ST_TRANSIT;
                        target_fwd_d = 1'b0;
                        hold_d       = HOLD_LOAD;
                    end else begin
                        state_d = ST_REV;
                    end
                end
                default: state_d = ST_BRAKE;
            endcase
        end else begin
            // Idle boundary: saturate at the limit so timeout stays latched.
            if (idle_q != IDLE_LIMIT) begin
                idle_d = idle_q + IDLE_W'(1);
            end else begin
                idle_d = idle_q;
            end
            if (idle_d == IDLE_LIMIT) begin
                state_d   = ST_BRAKE;
                timeout_d = 1'b1;
            end else begin
                state_d = state_q;
            end
        end
    end

    // Registered drive outputs follow the next state; direction is held while braking.
    always_comb begin
        brake_d = (state_d == ST_BRAKE) || (state_d == ST_TRANSIT);
        case (state_d)
            ST_FWD:  direction_d = 1'b1;
            ST_REV:  direction_d = 1'b0;
            default: direction_d = direction_q;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q      <= 30'd0;
            tick_q       <= (LAST_COUNT == 30'd0);
            state_q      <= ST_BRAKE;
            target_fwd_q <= 1'b0;
            hold_q       <= '0;
            idle_q       <= '0;
            timeout_q    <= 1'b0;
            direction_q  <= 1'b0;
            brake_q      <= 1'b1;
        end else begin
            count_q      <= count_d;
            tick_q       <= tick_d;
            state_q      <= state_d;
            target_fwd_q <= target_fwd_d;
            hold_q       <= hold_d;
            idle_q       <= idle_d;
            timeout_q    <= timeout_d;
            direction_q  <= direction_d;
            brake_q      <= brake_d;
        end
    end

    assign bus.ovr_grant = ovr_gnt_s;
    assign bus.nav_grant = nav_gnt_s;
    assign count_out     = count_q;
    assign period_tick   = tick_q;
    assign direction     = direction_q;
    assign motor_brake   = brake_q;
    assign timeout       = timeout_q;
endmodule

// File: tb/tb_servo_drive_scheduler.sv
// Directed bench for servo_drive_scheduler with PERIOD=10, HOLD_PERIODS=2,
// TIMEOUT_PERIODS=3: frame-level vector table plus hand-written corner sequences.
module tb_servo_drive_scheduler;
    logic        clk;
    logic        reset;
    logic [29:0] count_out;
    logic        period_tick;
    logic        direction;
    logic        motor_brake;
    logic        timeout;
    int          checks;
    int          failures;

    typedef struct packed {
        logic       ov;
        logic [1:0] oc;
        logic       nv;
        logic [1:0] nc;
        logic       e_og;
        logic       e_ng;
        logic       e_brk;
        logic       e_dir;
        logic       e_to;
    } vec_t;

    vec_t tbl [10];

    servo_drive_scheduler_if bus ();

    servo_drive_scheduler #(
        .PERIOD          (10),
        .HOLD_PERIODS    (2),
        .TIMEOUT_PERIODS (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .count_out   (count_out),
        .period_tick (period_tick),
        .direction   (direction),
        .motor_brake (motor_brake),
        .timeout     (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic wait_cnt(input logic [29:0] tgt);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((count_out !== tgt) && (n < 25));
        if (count_out !== tgt) begin
            checks++;
            failures++;
            $display("FAIL wait_count actual=%0d expected=%0d", count_out, tgt);
        end
    endtask

    task automatic drive(input logic ov, input logic [1:0] oc, input logic nv, input logic [1:0] nc);
        bus.ovr_valid = ov;
        bus.ovr_cmd   = oc;
        bus.nav_valid = nv;
        bus.nav_cmd   = nc;
    endtask

    initial begin
        int n;
        int bad;
        checks   = 0;
        failures = 0;

        //             ov  oc     nv  nc     og    ng    brk   dir   to
        tbl[0] = '{1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 2'b10, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 2'b11, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 2'b00, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        reset = 1'b1;
        drive(1'b0, 2'b00, 1'b0, 2'b00);
        repeat (3) @(negedge clk);
        chk("rst_count", 32'(count_out), 32'd0);
        chk("rst_tick", 32'(period_tick), 32'd0);
        chk("rst_brake", 32'(motor_brake), 32'd1);
        chk("rst_dir", 32'(direction), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_grants", 32'({bus.ovr_grant, bus.nav_grant}), 32'd0);
        reset = 1'b0;

        // Free-run one frame and into the next.
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            chk($sformatf("run_count%0d", i), 32'(count_out), 32'(i % 10));
            chk($sformatf("run_tick%0d", i), 32'(period_tick), (i % 10 == 9) ? 32'd1 : 32'd0);
            chk($sformatf("run_brake%0d", i), 32'(motor_brake), 32'd1);
        end

        // Frame-level vectors: request raised at count 3, grant seen at 9, outputs at 0.
        for (int v = 0; v < 10; v++) begin
            wait_cnt(30'd3);
            drive(tbl[v].ov, tbl[v].oc, tbl[v].nv, tbl[v].nc);
            wait_cnt(30'd9);
            chk($sformatf("vec%0d_tick", v), 32'(period_tick), 32'd1);
            chk($sformatf("vec%0d_ovr_grant", v), 32'(bus.ovr_grant), 32'(tbl[v].e_og));
            chk($sformatf("vec%0d_nav_grant", v), 32'(bus.nav_grant), 32'(tbl[v].e_ng));
            wait_cnt(30'd0);
            drive(1'b0, 2'b00, 1'b0, 2'b00);
            chk($sformatf("vec%0d_brake", v), 32'(motor_brake), 32'(tbl[v].e_brk));
            chk($sformatf("vec%0d_dir", v), 32'(direction), 32'(tbl[v].e_dir));
            chk($sformatf("vec%0d_timeout", v), 32'(timeout), 32'(tbl[v].e_to));
            chk($sformatf("vec%0d_grant_low", v), 32'({bus.ovr_grant, bus.nav_grant}), 32'd0);
        end

        // REV -> forward request: exactly 20 brake cycles before driving forward.
        wait_cnt(30'd3);
        drive(1'b0, 2'b00, 1'b1, 2'b01);
        wait_cnt(30'd9);
        chk("transit_nav_grant", 32'(bus.nav_grant), 32'd1);
        @(negedge clk);
        drive(1'b0, 2'b00, 1'b0, 2'b00);
        n = 0;
        while ((motor_brake === 1'b1) && (n < 40)) begin
            n++;
            @(negedge clk);
        end
        chk("transit_brake_cycles", 32'(n), 32'd20);
        chk("transit_exit_count", 32'(count_out), 32'd0);
        chk("transit_exit_dir", 32'(direction), 32'd1);

        // Idle timeout from FWD after three boundaries without a grant.
        wait_cnt(30'd9);
        wait_cnt(30'd0);
        wait_cnt(30'd9);
        wait_cnt(30'd0);
        chk("idle2_brake", 32'(motor_brake), 32'd0);
        chk("idle2_timeout", 32'(timeout), 32'd0);
        wait_cnt(30'd9);
        wait_cnt(30'd0);
        chk("idle3_brake", 32'(motor_brake), 32'd1);
        chk("idle3_timeout", 32'(timeout), 32'd1);
        chk("idle3_dir", 32'(direction), 32'd1);
        wait_cnt(30'd9);
        wait_cnt(30'd0);
        chk("idle4_timeout", 32'(timeout), 32'd1);
        wait_cnt(30'd3);
        drive(1'b0, 2'b00, 1'b1, 2'b01);
        wait_cnt(30'd9);
        chk("to_clear_grant", 32'(bus.nav_grant), 32'd1);
        wait_cnt(30'd0);
        drive(1'b0, 2'b00, 1'b0, 2'b00);
        chk("to_clear_timeout", 32'(timeout), 32'd0);
        chk("to_clear_brake", 32'(motor_brake), 32'd0);

        // Reset in the middle of a FWD->REV transit abandons the target.
        wait_cnt(30'd3);
        drive(1'b1, 2'b10, 1'b0, 2'b00);
        wait_cnt(30'd9);
        chk("rt_ovr_grant", 32'(bus.ovr_grant), 32'd1);
        wait_cnt(30'd0);
        drive(1'b0, 2'b00, 1'b0, 2'b00);
        chk("rt_in_transit", 32'(motor_brake), 32'd1);
        wait_cnt(30'd5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rt_count", 32'(count_out), 32'd0);
        chk("rt_brake", 32'(motor_brake), 32'd1);
        chk("rt_dir", 32'(direction), 32'd0);
        bad = 0;
        for (int c = 0; c < 35; c++) begin
            @(negedge clk);
            if ((motor_brake !== 1'b1) || (direction !== 1'b0)) bad++;
        end
        chk("rt_no_dir_change", 32'(bad), 32'd0);

        // Request held across reset is granted only at the first boundary after release.
        drive(1'b0, 2'b00, 1'b1, 2'b01);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((bus.nav_grant !== 1'b1) && (n < 30));
        chk("held_grant_cycle", 32'(n), 32'd9);
        chk("held_grant_count", 32'(count_out), 32'd9);
        wait_cnt(30'd0);
        drive(1'b0, 2'b00, 1'b0, 2'b00);
        chk("held_brake", 32'(motor_brake), 32'd0);
        chk("held_dir", 32'(direction), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
